// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the CPU pipeline: word type, fetch FSM states,
// and the IF/ID register payload.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        REDIR_PEND,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP   = 32'd4;
    localparam word_t NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, npc: 32'h0, valid: 1'b0};

    // Instruction addresses are word aligned; redirect targets are forced onto a word.
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: enable-gated load, synchronous flush that beats the
// enable, asynchronous active-low reset to a bubble.
module ifid_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IFID_BUBBLE;
        end else if (flush) begin
            q <= IFID_BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads, resolves redirects
// and halt, and drives the IF/ID register.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PCINIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ifW,
    input  logic        ifRST,
    input  logic        brnch_taken,
    input  logic [31:0] brnch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic [31:0] pc,
    output logic        halted
);

    fetch_state_t state;
    word_t        pend_target;
    logic         redirect;
    word_t        redir_target;
    logic         ifid_en;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    // Branch resolves in EX and is older than a JR/J decoded in ID, so it wins.
    always_comb begin
        redirect = brnch_taken | jr | jmp;
        if (brnch_taken) begin
            redir_target = word_align(brnch_target);
        end else if (jr) begin
            redir_target = word_align(jr_target);
        end else begin
            redir_target = word_align(jmp_target);
        end
    end

    // NOTE: every signal gets a default before the branches, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        ifid_en = 1'b0;
        ifid_d  = IFID_BUBBLE;
        if (halt || state == HALTED) begin
            ifid_en = 1'b1;
        end else if (state == REDIR_PEND || redirect) begin
            ifid_en = ihit | ifW;
        end else if (ihit) begin
            ifid_en = ifW;
            ifid_d  = '{instr: imemload, npc: pc + PC_STEP, valid: 1'b1};
        end else begin
            ifid_en = ifW;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc          <= PCINIT;
            pend_target <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (redirect) begin
                        if (ihit) begin
                            pc <= redir_target;
                        end else begin
                            // Keep pc (and so imemaddr) steady until the miss completes.
                            pend_target <= redir_target;
                            state       <= REDIR_PEND;
                        end
                    end else if (ihit && ifW) begin
                        pc <= pc + PC_STEP;
                    end
                end
                REDIR_PEND: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (ihit) begin
                        pc    <= redirect ? redir_target : pend_target;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_target <= redir_target;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    ifid_latch u_ifid_latch (
        .clk   (CLK),
        .rst_n (nRST),
        .en    (ifid_en),
        .flush (ifRST),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imemREN    = (state != HALTED);
    assign imemaddr   = word_align(pc);
    assign halted     = (state == HALTED);
    assign ifid_instr = ifid_q.instr;
    assign ifid_npc   = ifid_q.npc;
    assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural fetch model.
module tb_fetch_unit;

    localparam logic [31:0] PCINIT = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, ifW, ifRST, halt;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        brnch_taken, jr, jmp;
    logic [31:0] brnch_target, jr_target, jmp_target;
    logic [31:0] ifid_instr, ifid_npc, pc;
    logic        ifid_valid, halted;

    int total = 0;
    int bad   = 0;

    // Behavioural model: pc, optional pending redirect, halt flag, IF/ID contents.
    logic [31:0] m_pc, m_pend_tgt, m_instr, m_npc;
    logic        m_pend, m_halted, m_valid;
    logic [31:0] frozen_pc;

    fetch_unit #(.PCINIT(PCINIT)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .imemload     (imemload),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .ifW          (ifW),
        .ifRST        (ifRST),
        .brnch_taken  (brnch_taken),
        .brnch_target (brnch_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .halt         (halt),
        .ifid_instr   (ifid_instr),
        .ifid_npc     (ifid_npc),
        .ifid_valid   (ifid_valid),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0011;
            32'h0000_0104: return 32'h0000_0022;
            32'h0000_0108: return 32'h0000_0033;
            default:       return {a[15:0], ~a[31:16]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = PCINIT;  m_pend = 1'b0; m_pend_tgt = '0; m_halted = 1'b0;
        m_instr = '0;   m_npc = '0;    m_valid = 1'b0;
    endtask

    task automatic bubble();
        m_instr = '0; m_npc = '0; m_valid = 1'b0;
    endtask

    // Applies the fetch rules to the inputs present at the clock edge.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = brnch_taken | jr | jmp;
        tgt   = brnch_taken ? brnch_target : (jr ? jr_target : jmp_target);
        tgt   = tgt & ~32'h3;
        if (m_halted || halt) begin
            m_halted = 1'b1;
            bubble();
        end else if (m_pend) begin
            if (redir) m_pend_tgt = tgt;
            if (ihit) begin
                m_pc = m_pend_tgt; m_pend = 1'b0; bubble();
            end else if (ifW) begin
                bubble();
            end
        end else if (redir) begin
            if (ihit) begin
                m_pc = tgt; bubble();
            end else begin
                m_pend = 1'b1; m_pend_tgt = tgt;
                if (ifW) bubble();
            end
        end else if (ihit) begin
            if (ifW) begin
                m_instr = instr_at(m_pc); m_npc = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (ifW) begin
            bubble();
        end
        if (ifRST) bubble();
    endtask

    task automatic check_all();
        check("pc",         pc,         m_pc);
        check("imemaddr",   imemaddr,   m_pc);
        check("imemREN",    {31'b0, imemREN},    {31'b0, !m_halted});
        check("halted",     {31'b0, halted},     {31'b0, m_halted});
        check("ifid_instr", ifid_instr, m_instr);
        check("ifid_npc",   ifid_npc,   m_npc);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    endtask

    // One clock: update model at the edge, compare #1 later, then drop pulses.
    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
        brnch_taken = 1'b0; jr = 1'b0; jmp = 1'b0; halt = 1'b0;
        imemload = instr_at(m_pc);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b1; ifW = 1'b1; ifRST = 1'b0; halt = 1'b0;
        brnch_taken = 1'b0; jr = 1'b0; jmp = 1'b0;
        brnch_target = '0; jr_target = '0; jmp_target = '0;
        model_reset();
        imemload = instr_at(m_pc);
        #12;
        check_all();
        check("reset_pc", pc, PCINIT);
        nRST = 1'b1;

        // Back-to-back hits from PCINIT.
        step(); check("seq0_instr", ifid_instr, 32'h11); check("seq0_npc", ifid_npc, 32'h104);
        step(); check("seq1_instr", ifid_instr, 32'h22); check("seq1_npc", ifid_npc, 32'h108);
        step(); check("seq2_instr", ifid_instr, 32'h33); check("seq2_npc", ifid_npc, 32'h10C);

        // Stall at 0x200 for three cycles, then release.
        jmp = 1'b1; jmp_target = 32'h200; step();
        ifW = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_pc", pc, 32'h200);
        end
        ifW = 1'b1; step();
        check("stall_release_pc", pc, 32'h204);
        check("stall_release_instr", ifid_instr, instr_at(32'h200));

        // Branch beats jump in the same cycle.
        brnch_taken = 1'b1; brnch_target = 32'h400; jmp = 1'b1; jmp_target = 32'h800; step();
        check("prio_pc", pc, 32'h400);
        check("prio_valid", {31'b0, ifid_valid}, 32'h0);

        // Redirects during a miss at 0x500; the latest target wins.
        jmp = 1'b1; jmp_target = 32'h500; step();
        ihit = 1'b0; jmp = 1'b1; jmp_target = 32'h300; step();
        check("miss_addr0", imemaddr, 32'h500);
        brnch_taken = 1'b1; brnch_target = 32'h600; step();
        check("miss_addr1", imemaddr, 32'h500);
        step();
        check("miss_addr2", imemaddr, 32'h500);
        ihit = 1'b1; step();
        check("miss_redir_pc", pc, 32'h600);
        check("miss_redir_valid", {31'b0, ifid_valid}, 32'h0);

        // PC wrap at the top of the address space.
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC; step();
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_npc", ifid_npc, 32'h0);

        // Random traffic with unaligned targets and flushes.
        for (int i = 0; i < 400; i++) begin
            ihit = ($urandom_range(0, 3) != 0);
            ifW = ($urandom_range(0, 4) != 0);
            ifRST = ($urandom_range(0, 9) == 0);
            brnch_taken = ($urandom_range(0, 9) == 0);
            jr = ($urandom_range(0, 9) == 0);
            jmp = ($urandom_range(0, 9) == 0);
            brnch_target = $urandom; jr_target = $urandom; jmp_target = $urandom;
            step();
        end
        ifRST = 1'b0; ifW = 1'b1;

        // Async reset while a redirect is pending discards the saved target.
        ihit = 1'b0; jmp = 1'b1; jmp_target = 32'h700; step();
        nRST = 1'b0; #1;
        model_reset();
        check_all();
        check("pend_reset_pc", pc, PCINIT);
        #1 nRST = 1'b1;
        ihit = 1'b1; imemload = instr_at(m_pc); step();
        check("pend_reset_next_pc", pc, PCINIT + 32'd4);

        // Halt, then jumps must not move the pc; only reset recovers.
        frozen_pc = m_pc;
        halt = 1'b1; step();
        check("halt_flag", {31'b0, halted}, 32'h1);
        check("halt_ren", {31'b0, imemREN}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            jmp = 1'b1; jmp_target = 32'h900; step();
            check("halt_frozen_pc", pc, frozen_pc);
        end
        #2 nRST = 1'b0; #1;
        model_reset();
        check_all();
        check("halt_reset_pc", pc, PCINIT);
        check("halt_reset_halted", {31'b0, halted}, 32'h0);
        check("halt_reset_ren", {31'b0, imemREN}, 32'h1);
        nRST = 1'b1;
        imemload = instr_at(m_pc);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipelined CPU: owns the PC, issues instruction reads to the icache, resolves redirects (branch, JR, J/JAL) and halt, and drives the IF/ID pipeline register. It sits directly upstream of the hazard unit's control. It consumes the hazard unit's IF/ID write-enable (`ifW`) and flush (`ifRST`), and it produces the fetched instruction that the decode stage and hazard unit act on.

## Interface
Parameters:
- `PCINIT`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `CLK`  in  1  system clock, all state on rising edge.
- `nRST`  in  1  reset; one clock, reset is asynchronous and active-low.
- `ihit`  in  1  icache returns valid `imemload` this cycle.
- `imemload`  in  32  instruction word from icache.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction address, bits [1:0] always 0.
- `ifW`  in  1  IF/ID write enable from the hazard unit.
- `ifRST`  in  1  IF/ID flush from the hazard unit.
- `brnch_taken`  in  1  resolved taken branch (EX), single-cycle pulse.
- `brnch_target`  in  32  branch target.
- `jr`  in  1  JR resolved (ID), pulse.
- `jr_target`  in  32  register target.
- `jmp`  in  1  J/JAL decoded (ID), pulse.
- `jmp_target`  in  32  jump target.
- `halt`  in  1  HALT committed downstream.
- `ifid_instr`  out  32  IF/ID instruction, 0 (NOP) when bubble.
- `ifid_npc`  out  32  IF/ID PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `pc`  out  32  current PC.
- `halted`  out  1  fetch permanently stopped.

## Operation
- States: FETCH, REDIR_PEND, HALTED.
- Redirect priority: halt > `brnch_taken` > `jr` > `jmp`. Branch wins over a jump in the same cycle because the branch is the older instruction. The selected target has bits [1:0] forced to 0.
- FETCH: `imemREN`=1 and `imemaddr`=`pc`.
  - Redirect with `ihit`: `pc`<=target and IF/ID loads a bubble.
  - Redirect without `ihit`: the target is saved in the pending register and the state goes to REDIR_PEND. `pc` and `imemaddr` are held so that the outstanding icache request is kept stable.
  - No redirect, `ihit`, `ifW`=1: `pc`<=`pc`+4 and IF/ID <= {`imemload`, `pc`+4, valid=1}.
  - `ihit` with `ifW`=0: stall. `pc` and IF/ID are held, and the same address is refetched.
  - No `ihit`: hold. IF/ID loads a bubble if `ifW`=1, otherwise it holds.
- REDIR_PEND: `imemREN`=1 and `imemaddr`=old `pc`.
  - A new redirect overwrites the saved target (latest wins).
  - On `ihit` the data is discarded, `pc`<=saved target, IF/ID loads a bubble, and the state returns to FETCH.
- HALTED: entered from any state on `halt`=1.
  - `imemREN`=0, `pc` frozen, IF/ID bubble, `halted`=1.
  - Left only by reset.
- `ifRST`=1 overrides every IF/ID write and forces a bubble (instr=0, npc=0, valid=0), with or without `ifW`. `ifRST` does not affect `pc`.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values (async): `pc`=`PCINIT`, state=FETCH, pending target=0, `ifid_instr`=0, `ifid_npc`=0, `ifid_valid`=0, `halted`=0. `imemREN`=1 and `imemaddr`=`PCINIT` combinationally right after reset deassertion.
- Fetch latency: the instruction appears on IF/ID outputs the edge after the `ihit` cycle. Back-to-back hits give one instruction per cycle.
- A redirect with `ihit` takes effect the next edge, and `imemaddr` shows the target the following cycle.
- A redirect without `ihit` takes effect the edge after the eventual `ihit`. The fetch penalty is the remaining miss cycles + 1.
- `halt` takes effect on the next edge, and `imemREN` drops the same cycle the state becomes HALTED.
- Reset mid-REDIR_PEND discards the pending target.
- `imemaddr`, `imemREN` and `pc` are Moore outputs (functions of state/registers only).

## Structure
- `cpu_types_pkg`: `word_t` (32-bit), `fetch_state_t` enum {FETCH, REDIR_PEND, HALTED}, `PC_STEP`=4, `NOP_INSTR`=32'h0.
- One sub-module: `ifid_latch`. It is the IF/ID register with enable, synchronous flush (flush over enable) and async active-low reset, and it holds instr/npc/valid.
- `fetch_unit` holds the PC, the pending-target register, the state machine and the next-PC mux.

## Test plan
- Reset with `PCINIT`=0x100, `ihit`=1 constant, `ifW`=1, and `imemload` = 0x11, 0x22, 0x33 at 0x100/0x104/0x108. Required: `ifid_instr` shows 0x11, 0x22, 0x33 on consecutive cycles with `ifid_npc` = 0x104, 0x108, 0x10C.
- `ihit`=1 with `ifW`=0 for 3 cycles at `pc`=0x200. Required: `pc` stays 0x200 and IF/ID is unchanged. After `ifW`=1, the instruction at 0x200 is latched and `pc` becomes 0x204.
- `brnch_taken` (target 0x400) and `jmp` (target 0x800) in the same cycle with `ihit`=1. Required: next `pc`=0x400, and IF/ID is a bubble (valid=0, instr=0).
- `jmp` target 0x300 during an icache miss at 0x500, then `brnch_taken` target 0x600 one cycle later, then `ihit` two cycles after that. Required: `imemaddr` holds 0x500 throughout, then `pc`=0x600, and no instruction from 0x500 enters IF/ID.
- `pc`=0xFFFF_FFFC with `ihit` and `ifW`. Required: `pc` wraps to 0 and `ifid_npc`=0.
- `halt` pulse. Required: `halted`=1 and `imemREN`=0 from the next cycle, `pc` is frozen even if `jmp` pulses afterward, and asserting `nRST` low asynchronously restores `pc`=`PCINIT` and `halted`=0.
